// File: rtl/reg_lock_tracker.sv
// Destination-register scoreboard: locks rd on issue, unlocks on writeback,
// and blocks all issue (locks_o all-ones) while a jump is outstanding.
package rv64g_pkg;
   localparam int NUM_REGS = 32;
endpackage

// One-hot decode of a register index; index 0 and out-of-range indices decode to nothing.
module reg_lock_dec #(
   parameter int NR = 32,
   parameter int RW = $clog2(NR)
) (
   input  logic          vld,
   input  logic [RW-1:0] rd,
   output logic [NR-1:0] mask
);
   always_comb begin
      mask = '0;
      if (vld && rd != '0 && int'(rd) < NR) mask[rd] = 1'b1;
   end
endmodule

module reg_lock_tracker #(
   parameter int NR  = rv64g_pkg::NUM_REGS,
   parameter int NWB = 2
) (
   input  logic                              clk_i,
   input  logic                              arst_ni,
   input  logic                              issue_valid_i,
   input  logic                              issue_jump_i,
   input  logic [$clog2(NR)-1:0]             issue_rd_i,
   output logic                              issue_ready_o,
   input  logic [NWB-1:0]                    wb_valid_i,
   input  logic [NWB-1:0][$clog2(NR)-1:0]    wb_rd_i,
   input  logic                              jump_done_i,
   input  logic                              flush_i,
   output logic [NR-1:0]                     locks_o,
   output logic                              jump_pending_o,
   output logic [$clog2(NR):0]               lock_cnt_o
);
   localparam int RW = $clog2(NR);
   localparam int CW = $clog2(NR) + 1;

   typedef enum logic {IDLE, JUMP} state_t;

   state_t                 state_q;
   logic [NR-1:0]          lock_q;
   logic [NWB-1:0][NR-1:0] wb_mask;
   logic [NR-1:0]          clr_mask;
   logic [NR-1:0]          set_mask;
   logic                   accept;

   assign accept = issue_valid_i && (state_q == IDLE);

   for (genvar k = 0; k < NWB; k++) begin : g_wb
      reg_lock_dec #(.NR(NR), .RW(RW)) u_dec (
         .vld  (wb_valid_i[k]),
         .rd   (wb_rd_i[k]),
         .mask (wb_mask[k])
      );
   end

   reg_lock_dec #(.NR(NR), .RW(RW)) u_set_dec (
      .vld  (accept && !issue_jump_i),
      .rd   (issue_rd_i),
      .mask (set_mask)
   );

   always_comb begin
      clr_mask = '0;
      for (int k = 0; k < NWB; k++) clr_mask = clr_mask | wb_mask[k];
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= IDLE;
         lock_q  <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
         lock_q  <= '0;
      end else begin
         // Set is OR-ed after the clear so a same-cycle reissue keeps the lock.
         lock_q <= (lock_q & ~clr_mask) | set_mask;
         case (state_q)
            IDLE:    if (accept && issue_jump_i) state_q <= JUMP;
            JUMP:    if (jump_done_i)            state_q <= IDLE;
            default:                             state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      lock_cnt_o = '0;
      for (int i = 0; i < NR; i++) lock_cnt_o = lock_cnt_o + CW'(lock_q[i]);
   end

   assign locks_o        = (state_q == JUMP) ? '1 : lock_q;
   assign issue_ready_o  = (state_q == IDLE);
   assign jump_pending_o = (state_q == JUMP);
endmodule

// File: tb/tb_reg_lock_tracker.sv
// Randomized and directed checks of reg_lock_tracker against a behavioural lock-set model.
module tb_reg_lock_tracker;
   localparam int NR  = 32;
   localparam int NWB = 2;
   localparam int RW  = 5;

   logic                       clk_i = 1'b0;
   logic                       arst_ni;
   logic                       issue_valid_i, issue_jump_i;
   logic [RW-1:0]              issue_rd_i;
   logic                       issue_ready_o;
   logic [NWB-1:0]             wb_valid_i;
   logic [NWB-1:0][RW-1:0]     wb_rd_i;
   logic                       jump_done_i, flush_i;
   logic [NR-1:0]              locks_o;
   logic                       jump_pending_o;
   logic [RW:0]                lock_cnt_o;

   int checks = 0;
   int errors = 0;

   bit mdl_lock[NR];
   bit mdl_jump;

   reg_lock_tracker #(.NR(NR), .NWB(NWB)) dut (
      .clk_i          (clk_i),
      .arst_ni        (arst_ni),
      .issue_valid_i  (issue_valid_i),
      .issue_jump_i   (issue_jump_i),
      .issue_rd_i     (issue_rd_i),
      .issue_ready_o  (issue_ready_o),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_i        (wb_rd_i),
      .jump_done_i    (jump_done_i),
      .flush_i        (flush_i),
      .locks_o        (locks_o),
      .jump_pending_o (jump_pending_o),
      .lock_cnt_o     (lock_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR-1:0] mdl_locks();
      logic [NR-1:0] v;
      if (mdl_jump) return '1;
      for (int i = 0; i < NR; i++) v[i] = mdl_lock[i];
      return v;
   endfunction

   function automatic int mdl_cnt();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(mdl_lock[i]);
      return n;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_locks"}, 64'(locks_o), 64'(mdl_locks()));
      chk({tag, "_ready"}, 64'(issue_ready_o), 64'(!mdl_jump));
      chk({tag, "_jpend"}, 64'(jump_pending_o), 64'(mdl_jump));
      chk({tag, "_cnt"}, 64'(lock_cnt_o), 64'(mdl_cnt()));
   endtask

   task automatic model_reset();
      foreach (mdl_lock[i]) mdl_lock[i] = 1'b0;
      mdl_jump = 1'b0;
   endtask

   // Advance one clock with the currently driven inputs, updating the model in step.
   task automatic cycle();
      bit nl[NR];
      bit nj;
      nl = mdl_lock;
      nj = mdl_jump;
      if (flush_i) begin
         foreach (nl[i]) nl[i] = 1'b0;
         nj = 1'b0;
      end else begin
         for (int k = 0; k < NWB; k++)
            if (wb_valid_i[k] && wb_rd_i[k] != 0) nl[wb_rd_i[k]] = 1'b0;
         if (!mdl_jump) begin
            if (issue_valid_i) begin
               if (issue_jump_i) nj = 1'b1;
               else if (issue_rd_i != 0) nl[issue_rd_i] = 1'b1;
            end
         end else if (jump_done_i) nj = 1'b0;
      end
      @(posedge clk_i);
      mdl_lock = nl;
      mdl_jump = nj;
      @(negedge clk_i);
   endtask

   task automatic drive(input bit v, input bit j, input int rd, input logic [1:0] wv,
                        input int w0, input int w1, input bit done, input bit fl);
      issue_valid_i = v;
      issue_jump_i  = j;
      issue_rd_i    = RW'(rd);
      wb_valid_i    = wv;
      wb_rd_i[0]    = RW'(w0);
      wb_rd_i[1]    = RW'(w1);
      jump_done_i   = done;
      flush_i       = fl;
      cycle();
      issue_valid_i = 0; issue_jump_i = 0; issue_rd_i = '0;
      wb_valid_i = '0; wb_rd_i = '0; jump_done_i = 0; flush_i = 0;
   endtask

   initial begin
      arst_ni = 1'b0;
      issue_valid_i = 0; issue_jump_i = 0; issue_rd_i = '0;
      wb_valid_i = '0; wb_rd_i = '0; jump_done_i = 0; flush_i = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk_i);
      arst_ni = 1'b1;

      // lock then unlock rd 5
      drive(1, 0, 5, 2'b00, 0, 0, 0, 0);
      chk("r5_lock", 64'(locks_o), 64'h20);
      chk("r5_cnt", 64'(lock_cnt_o), 64'd1);
      drive(0, 0, 0, 2'b01, 5, 0, 0, 0);
      chk("r5_unlock", 64'(locks_o), 64'h0);
      chk("r5_cnt0", 64'(lock_cnt_o), 64'd0);

      // x0 is never tracked
      drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("x0_issue", 64'(locks_o), 64'h0);
      drive(0, 0, 0, 2'b11, 0, 0, 0, 0);
      chk("x0_wb", 64'(locks_o), 64'h0);
      chk("x0_cnt", 64'(lock_cnt_o), 64'd0);

      // jump blocks everything; writeback still drains during JUMP
      drive(1, 0, 3, 2'b00, 0, 0, 0, 0);
      drive(1, 0, 7, 2'b00, 0, 0, 0, 0);
      drive(1, 1, 12, 2'b00, 0, 0, 0, 0);
      chk("jmp_locks", 64'(locks_o), 64'hFFFF_FFFF);
      chk("jmp_ready", 64'(issue_ready_o), 64'd0);
      drive(1, 0, 4, 2'b10, 0, 3, 0, 0);
      check_all("jmp_wb");
      drive(0, 0, 0, 2'b00, 0, 0, 1, 0);
      chk("jmp_done", 64'(locks_o), 64'h80);
      chk("jmp_ready1", 64'(issue_ready_o), 64'd1);

      // set wins over same-cycle clear
      drive(1, 0, 9, 2'b00, 0, 0, 0, 0);
      chk("sw_cnt_before", 64'(lock_cnt_o), 64'd2);
      drive(1, 0, 9, 2'b11, 9, 9, 0, 0);
      chk("sw_locks", 64'(locks_o), 64'h280);
      chk("sw_cnt", 64'(lock_cnt_o), 64'd2);

      // flush overrides issue and jump_done
      drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
      for (int r = 1; r <= 10; r++) drive(1, 0, r, 2'b00, 0, 0, 0, 0);
      chk("fl_cnt10", 64'(lock_cnt_o), 64'd10);
      drive(1, 1, 0, 2'b00, 0, 0, 0, 0);
      drive(1, 0, 20, 2'b00, 0, 0, 1, 1);
      chk("fl_locks", 64'(locks_o), 64'h0);
      chk("fl_ready", 64'(issue_ready_o), 64'd1);
      chk("fl_cnt", 64'(lock_cnt_o), 64'd0);

      // async reset between edges
      drive(1, 0, 11, 2'b00, 0, 0, 0, 0);
      drive(1, 1, 0, 2'b00, 0, 0, 0, 0);
      @(posedge clk_i);
      #2 arst_ni = 1'b0;
      #1;
      model_reset();
      chk("ar_locks", 64'(locks_o), 64'h0);
      chk("ar_ready", 64'(issue_ready_o), 64'd1);
      chk("ar_jpend", 64'(jump_pending_o), 64'd0);
      chk("ar_cnt", 64'(lock_cnt_o), 64'd0);
      @(negedge clk_i);
      arst_ni = 1'b1;
      drive(1, 0, 6, 2'b00, 0, 0, 0, 0);
      chk("ar_first", 64'(locks_o), 64'h40);

      // random traffic
      for (int n = 0; n < 500; n++) begin
         drive(($urandom_range(1, 0) == 1), ($urandom_range(7, 0) == 0), int'($urandom_range(31, 0)),
               2'($urandom_range(3, 0)), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
               ($urandom_range(3, 0) == 0), ($urandom_range(31, 0) == 0));
         check_all("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
